// File: rtl/uart_pkg.sv
// Shared UART constants: FIFO geometry, character width, and the
// positions of the per-character error flags.
package uart_pkg;
  localparam int UART_FIFO_ADDR_W = 4;
  localparam int UART_DATA_W      = 8;
  localparam int UART_ERR_W       = 3;

  // Bit positions within the per-character error field
  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
  localparam int ERR_BREAK   = 2;
endpackage

// File: rtl/raminfr.sv
// Inferred dual-port RAM: synchronous write port, asynchronous read port.
//  clk   in   write clock
//  we    in   write enable
//  a     in   write address
//  dpra  in   read address (async)
//  di    in   write data
//  dpo   out  read data at dpra
module raminfr #(
  parameter int addr_width = 4,
  parameter int data_width = 8,
  parameter int depth      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] a,
  input  logic [addr_width-1:0] dpra,
  input  logic [data_width-1:0] di,
  output logic [data_width-1:0] dpo
);
  logic [data_width-1:0] ram [0:depth-1];

  always_ff @(posedge clk)
    if (we) ram[a] <= di;

  assign dpo = ram[dpra];
endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO controller between the UART receive shifter and the bus
// read path. Data bytes are held in raminfr; error flags are held in a
// local flop array that is written alongside the RAM.
//  clk, rst_n          clock, synchronous active-low reset
//  fifo_clr            flush FIFO state (overrun is kept)
//  push/push_data/err  receiver write side
//  pop                 bus read strobe (RBR read)
//  pop_data/pop_err    head entry, 0 when empty
//  count/empty/full    occupancy
//  overrun/ovr_clr     sticky overrun flag and its clear
//  err_any             some held entry carries an error flag (LSR[7])
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_W = UART_FIFO_ADDR_W,
  parameter int DATA_W = UART_DATA_W,
  parameter int ERR_W  = UART_ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ERR_W-1:0]  push_err,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [ERR_W-1:0]  pop_err,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              err_any
);
  localparam int DEPTH = 2**ADDR_W;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   err_cnt;
  logic [ERR_W-1:0]  errmem [0:DEPTH-1];
  logic [DATA_W-1:0] ram_q;
  logic [ERR_W-1:0]  err_q;
  logic              pop_acc, push_acc, push_rej, err_inc, err_dec;

  assign empty   = (count == '0);
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign err_any = (err_cnt != '0);

  // A flush or reset swallows any same-cycle traffic, including RAM writes.
  // Popping a full FIFO frees the slot the push needs.
  assign pop_acc  = rst_n && !fifo_clr && pop && !empty;
  assign push_acc = rst_n && !fifo_clr && push && (!full || pop_acc);
  assign push_rej = rst_n && !fifo_clr && push && full && !pop_acc;
  assign err_inc  = push_acc && (|push_err);
  assign err_dec  = pop_acc && (|err_q);

  raminfr #(
    .addr_width(ADDR_W),
    .data_width(DATA_W),
    .depth     (DEPTH)
  ) u_ram (
    .clk (clk),
    .we  (push_acc),
    .a   (wr_ptr),
    .dpra(rd_ptr),
    .di  (push_data),
    .dpo (ram_q)
  );

  always_ff @(posedge clk)
    if (push_acc) errmem[wr_ptr] <= push_err;

  assign err_q    = errmem[rd_ptr];
  assign pop_data = empty ? '0 : ram_q;
  assign pop_err  = empty ? '0 : err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else if (fifo_clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      if (push_acc && !pop_acc)      count <= count + 1'b1;
      else if (pop_acc && !push_acc) count <= count - 1'b1;
      if (err_inc && !err_dec)       err_cnt <= err_cnt + 1'b1;
      else if (err_dec && !err_inc)  err_cnt <= err_cnt - 1'b1;
    end
  end

  // Overrun survives a flush; a new overrun wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n)        overrun <= 1'b0;
    else if (push_rej) overrun <= 1'b1;
    else if (ovr_clr)  overrun <= 1'b0;
  end
endmodule
